// File: rtl/poly_mod_add_pipe.sv
// Two-stage pipelined modular adder: o = (a+b) mod Q with valid/ready flow control,
// a per-polynomial coefficient index, and a sticky out-of-range operand flag.
`timescale 1ns/1ps
module poly_mod_add_pipe #(
    parameter int WIDTH = 12,
    parameter int Q     = 3329,
    parameter int N     = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             out_last,
    output logic [7:0]       out_idx,
    output logic             err
);
    localparam logic [WIDTH:0] QW       = (WIDTH+1)'(Q);
    localparam logic [7:0]     LAST_IDX = 8'(N-1);

    logic             r_s1_valid, r_s1_bad, r_s2_valid, r_err;
    logic [WIDTH:0]   r_s1_sum;
    logic [WIDTH-1:0] r_o;
    logic [7:0]       r_idx;

    logic             w_s1_load, w_s2_load, w_out_xfer, w_bad_in, w_wrap;
    logic [WIDTH-1:0] w_red;

    assign w_s2_load  = !r_s2_valid || out_ready;
    assign w_s1_load  = !r_s1_valid || w_s2_load;
    assign in_ready   = !r_s1_valid || !r_s2_valid || out_ready;
    assign w_out_xfer = r_s2_valid && out_ready;
    assign w_wrap     = (r_idx == LAST_IDX);
    assign w_bad_in   = ({1'b0, a} >= QW) || ({1'b0, b} >= QW);
    // Single conditional subtract; out-of-range operands just take this same path.
    assign w_red      = (r_s1_sum >= QW) ? WIDTH'(r_s1_sum - QW) : WIDTH'(r_s1_sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_bad   <= 1'b0;
            r_s1_sum   <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            r_s1_bad   <= w_bad_in;
            r_s1_sum   <= {1'b0, a} + {1'b0, b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_o        <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            r_o        <= w_red;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_out_xfer) begin
            r_idx <= w_wrap ? 8'd0 : r_idx + 8'd1;
        end
    end

    // A bad entry entering stage 2 sets the flag even on the boundary transfer that would clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_s2_load && r_s1_valid && r_s1_bad) begin
            r_err <= 1'b1;
        end else if (w_out_xfer && w_wrap) begin
            r_err <= 1'b0;
        end
    end

    assign out_valid = r_s2_valid;
    assign o         = r_o;
    assign out_idx   = r_idx;
    assign out_last  = r_s2_valid && w_wrap;
    assign err       = r_err;
endmodule

// File: tb/tb_poly_mod_add_pipe.sv
// Scoreboard bench for poly_mod_add_pipe: random and directed pairs, random backpressure,
// reference model of (a+b) mod Q, coefficient index and sticky error flag.
`timescale 1ns/1ps
module tb_poly_mod_add_pipe;
    localparam int W = 12;
    localparam int Q = 3329;
    localparam int N = 256;

    logic         clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, out_last, err;
    logic [W-1:0] o;
    logic [7:0]   out_idx;

    poly_mod_add_pipe #(.WIDTH(W), .Q(Q), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .o(o), .out_last(out_last), .out_idx(out_idx), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { int o; bit bad; } exp_t;
    exp_t q[$];
    exp_t e_in, cur;
    int   n_chk = 0, n_fail = 0, n_acc = 0, n_last = 0;
    int   mdl_idx = 0, rdy_mode = 0;
    bit   mdl_err = 0, xerr, prev_stall = 0;
    int   prev_o = 0, prev_idx = 0;

    task automatic chk(input string nm, input int act, input int want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, want, $time);
        end
    endtask

    // Reference: plain modular sum; out-of-range sums keep the one-subtract result in W bits.
    function automatic int ref_add(input int x, input int y);
        int s = x + y;
        return ((s >= Q) ? s - Q : s) % (1 << W);
    endfunction

    // Stimulus side: every accepted pair pushes its expected result.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            e_in.o   = ref_add(int'(a), int'(b));
            e_in.bad = (int'(a) >= Q) || (int'(b) >= Q);
            q.push_back(e_in);
            n_acc++;
        end
    end

    // Monitor: compare every presented result; track index, sticky error and stall stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            mdl_idx    = 0;
            mdl_err    = 0;
            prev_stall = 0;
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    cur  = q[0];
                    xerr = mdl_err | cur.bad;
                    chk("o", int'(o), cur.o);
                    chk("out_idx", int'(out_idx), mdl_idx);
                    chk("out_last", int'(out_last), int'(mdl_idx == N-1));
                    chk("err", int'(err), int'(xerr));
                    if (prev_stall) begin
                        chk("stall_o_stable", int'(o), prev_o);
                        chk("stall_idx_stable", int'(out_idx), prev_idx);
                    end
                    if (out_ready) begin
                        void'(q.pop_front());
                        if (out_last) n_last++;
                        mdl_err = (mdl_idx == N-1) ? 1'b0 : xerr;
                        mdl_idx = (mdl_idx + 1) % N;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_o     = int'(o);
            prev_idx   = int'(out_idx);
        end
    end

    // Backpressure driver: 0 = always ready, 1 = random, 2 = left to the main sequence.
    initial forever begin
        @(posedge clk); #1;
        if (rdy_mode == 0) out_ready = 1'b1;
        else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input int x, input int y);
        bit ok = 0;
        in_valid = 1'b1; a = W'(x); b = W'(y);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 3000 && q.size() != 0; t++) @(negedge clk);
        chk("drain_empty", q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_o", int'(o), 0);
        chk("rst_idx", int'(out_idx), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_last", int'(out_last), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1 chk("post_rst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, last0;
        rdy_mode = 0;
        do_reset();

        // Single pair: 2-cycle latency, index 0.
        send(1000, 2000);
        @(negedge clk); chk("lat_not_yet", int'(out_valid), 0);
        @(negedge clk); chk("lat_valid", int'(out_valid), 1);
        chk("lat_o", int'(o), 3000);
        chk("lat_idx", int'(out_idx), 0);
        drain();

        // Boundary sums back-to-back.
        send(3328, 1); send(3328, 3328); send(0, 0); send(1664, 1665);
        drain();

        // Full stall: exactly two pairs accepted, then released in order.
        rdy_mode = 2; out_ready = 1'b0;
        acc0 = n_acc;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = W'($urandom_range(0, Q-1)); b = W'($urandom_range(0, Q-1));
            @(posedge clk); #1;
        end
        chk("stall_accepted", n_acc - acc0, 2);
        chk("stall_in_ready", int'(in_ready), 0);
        in_valid = 1'b0; rdy_mode = 0; out_ready = 1'b1;
        drain();

        // Full random polynomial with random backpressure.
        do_reset();
        rdy_mode = 1; last0 = n_last;
        for (int i = 0; i < N; i++) begin
            send(int'($urandom_range(0, Q-1)), int'($urandom_range(0, Q-1)));
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        drain();
        chk("poly_last_count", n_last - last0, 1);
        chk("poly_idx_wrap", int'(out_idx), 0);

        // Out-of-range operand at index 5: sticky to the polynomial boundary.
        do_reset();
        for (int i = 0; i < N + 3; i++) begin
            if (i == 5) send(4095, 0);
            else send(int'($urandom_range(0, Q-1)), int'($urandom_range(0, Q-1)));
        end
        drain();
        chk("err_cleared", int'(err), 0);

        // Mid-stream reset with two pairs in flight at index 100.
        do_reset();
        rdy_mode = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 50) send(4000, 10);
            else send(int'($urandom_range(0, Q-1)), int'($urandom_range(0, Q-1)));
        end
        drain();
        chk("pre_rst_idx", int'(out_idx), 100);
        chk("pre_rst_err", int'(err), 1);
        rdy_mode = 2; out_ready = 1'b0;
        send(11, 22); send(33, 44);
        chk("inflight_valid", int'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", int'(out_valid), 0);
        chk("async_o", int'(o), 0);
        chk("async_idx", int'(out_idx), 0);
        chk("async_err", int'(err), 0);
        chk("async_in_ready", int'(in_ready), 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        rdy_mode = 0;
        @(posedge clk); #1;
        send(7, 8);
        drain();
        chk("after_rst_idx", int'(out_idx), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/poly_mod_add_pipe.md
POLY_MOD_ADD_PIPE -- requirements
Module: poly_mod_add_pipe

Interface
REQ-001 Parameter WIDTH, default 12, coefficient width in bits.
REQ-002 Parameter Q, default 3329, modulus.
REQ-003 Parameter N, default 256, coefficients per polynomial.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  a/b pair present.
REQ-007 in_ready  output  1  block accepts the pair this cycle.
REQ-008 a  input  WIDTH  first operand, nominal range 0..Q-1.
REQ-009 b  input  WIDTH  second operand, nominal range 0..Q-1.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 o  output  WIDTH  (a+b) mod Q.
REQ-013 out_last  output  1  marks coefficient N-1 of the current polynomial.
REQ-014 out_idx  output  8  index of the coefficient currently on o, 0..N-1.
REQ-015 err  output  1  sticky out-of-range operand flag.

Function
REQ-016 A transfer SHALL occur on the input side when in_valid && in_ready, and on the output side when out_valid && out_ready.
REQ-017 Stage 1 SHALL register s1_sum = a+b at WIDTH+1 bits (max 8190, no truncation), plus s1_valid and s1_bad = (a>=Q)||(b>=Q).
REQ-018 Stage 2 SHALL register o = (s1_sum>=Q) ? s1_sum-Q : s1_sum, truncated to WIDTH bits, plus s2_valid.
REQ-019 The result SHALL equal (a+b) mod Q for all operands in 0..Q-1; a single conditional subtract is the only reduction.
REQ-020 Operands >=Q SHALL still flow through the single-subtract path; the output value is then unspecified beyond REQ-018.
REQ-021 Stage 2 SHALL load when !s2_valid || out_ready.
REQ-022 Stage 1 SHALL load when !s1_valid || stage 2 loads.
REQ-023 in_ready SHALL equal !s1_valid || !s2_valid || out_ready (combinational).
REQ-024 Latency SHALL be exactly 2 cycles from input transfer to out_valid with no stall; throughput one pair per cycle with out_ready held high.
REQ-025 While out_valid && !out_ready, o, out_idx, and out_last SHALL remain stable, and no accepted pair SHALL be lost or duplicated.
REQ-026 A stage that loads with no incoming valid SHALL clear its valid bit (bubble).
REQ-027 The output counter out_idx SHALL increment on each output transfer and wrap from N-1 to 0.
REQ-028 out_last SHALL be out_valid && (out_idx==N-1).
REQ-029 err SHALL set when a stage-1 entry with s1_bad=1 moves to stage 2.
REQ-030 err SHALL clear only on reset, or on the output transfer of index N-1 (polynomial boundary) when no new bad entry sets it in the same cycle; set wins over clear.
REQ-031 Simultaneous input and output transfers SHALL be supported in the same cycle with full occupancy.

Reset
REQ-032 When rst_n=0, s1_valid, s2_valid, out_valid, out_last, err, out_idx, and o SHALL be 0 immediately, independent of clk.
REQ-033 in_ready SHALL be 1 while in reset and in the first cycle after release.
REQ-034 Reset asserted mid-stream SHALL discard all in-flight pairs; after release, the first result SHALL carry out_idx=0.

Verification
REQ-035 a=1000, b=2000, out_ready=1 -> o=3000 with out_valid two cycles later, out_idx=0.
REQ-036 (3328,1), (3328,3328), (0,0), (1664,1665) back-to-back -> o = 0, 3327, 0, 0 on consecutive cycles.
REQ-037 Stream 256 random pairs in range, with out_ready toggling randomly -> results match the reference model in order, o is stable during stalls, out_last=1 only on the 256th result, and out_idx returns to 0.
REQ-038 Hold out_ready=0 with in_valid=1 -> exactly two pairs accepted, then in_ready=0; release out_ready -> both results delivered in order with no loss.
REQ-039 a=4095, b=0 at index 5 -> err=1 from that output onward; err stays high through index 255, then clears after the index-255 transfer.
REQ-040 Assert rst_n=0 with 2 pairs in flight at out_idx=100 -> outputs drop to 0 asynchronously; the next accepted pair emerges with out_idx=0.
